// File: rtl/result_pkg.sv
// Shared constants for the result drain: header byte, FSM encoding and default frame geometry.
package result_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_ACC_W = 24;

    localparam int BYTES_PER_PE     = DEF_ACC_W / 8;
    localparam int FRAME_DATA_BYTES = DEF_ROWS * DEF_COLS * BYTES_PER_PE;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_HDR  = ST_HDR,
        S_DATA = ST_DATA,
        S_CSUM = ST_CSUM,
        S_FIN  = ST_FIN
    } state_t;

endpackage

// File: rtl/result_byte_sel.sv
// Picks one byte of the accumulator snapshot: PE idx, byte byte_idx counted from the MSB.
module result_byte_sel #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int ACC_W  = 24,
    parameter int IDX_W  = 6,
    parameter int BYTE_W = 2
) (
    input  logic [ROWS*COLS*ACC_W-1:0] snap,
    input  logic [IDX_W-1:0]           idx,
    input  logic [BYTE_W-1:0]          byte_idx,
    output logic [7:0]                 value
);

    localparam int SEL_W = $clog2(ROWS * COLS * ACC_W);

    logic [SEL_W-1:0] base_s;

    // Top bit of the selected byte within the flattened snapshot
    always_comb begin
        base_s = SEL_W'(int'(idx) * ACC_W + ACC_W - 1 - 8 * int'(byte_idx));
        value  = snap[base_s -: 8];
    end

endmodule

// File: rtl/result_drain.sv
// Snapshots the PE accumulator bus on a compute_done rise and streams it as a byte frame.
// Optional trailing checksum byte when RESULT_DRAIN_CHECKSUM_EN is defined.
module result_drain
    import result_pkg::*;
#(
    parameter int         ROWS  = DEF_ROWS,
    parameter int         COLS  = DEF_COLS,
    parameter int         ACC_W = DEF_ACC_W,
    parameter logic [7:0] HDR   = HDR_BYTE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       compute_done,
    input  logic [ROWS*COLS*ACC_W-1:0] pe_register_vals,
    output logic [7:0]                 out_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int NPE    = ROWS * COLS;
    localparam int BPP    = ACC_W / 8;
    localparam int IDX_W  = (NPE > 1) ? $clog2(NPE) : 1;
    localparam int BYTE_W = (BPP > 1) ? $clog2(BPP) : 1;

    state_t                     state_r;
    logic                       cd_q_r;
    logic [ROWS*COLS*ACC_W-1:0] snap_r;
    logic [IDX_W-1:0]           idx_r;
    logic [BYTE_W-1:0]          byte_r;
    logic [7:0]                 out_byte_r;
    logic                       out_valid_r;
    logic                       busy_r;
    logic                       frame_done_r;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [7:0]                 csum_r;
`endif

    logic              start_s;
    logic              xfer_s;
    logic              last_s;
    logic [IDX_W-1:0]  next_idx_s;
    logic [BYTE_W-1:0] next_byte_s;
    logic [7:0]        sel_byte_s;

    assign start_s = compute_done & ~cd_q_r;
    assign xfer_s  = out_valid_r & out_ready;
    assign last_s  = (idx_r == IDX_W'(NPE - 1)) && (byte_r == BYTE_W'(BPP - 1));

    assign out_byte   = out_byte_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Position of the byte that follows the one currently presented
    always_comb begin
        next_idx_s  = idx_r;
        next_byte_s = byte_r;
        if (state_r == S_HDR) begin
            next_idx_s  = '0;
            next_byte_s = '0;
        end else if (byte_r == BYTE_W'(BPP - 1)) begin
            next_idx_s  = idx_r + IDX_W'(1);
            next_byte_s = '0;
        end else begin
            next_byte_s = byte_r + BYTE_W'(1);
        end
    end

    result_byte_sel #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ACC_W  (ACC_W),
        .IDX_W  (IDX_W),
        .BYTE_W (BYTE_W)
    ) u_byte_sel (
        .snap     (snap_r),
        .idx      (next_idx_s),
        .byte_idx (next_byte_s),
        .value    (sel_byte_s)
    );

    // Frame sequencer: edge detect, snapshot, counters, checksum and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            cd_q_r       <= 1'b0;
            snap_r       <= '0;
            idx_r        <= '0;
            byte_r       <= '0;
            out_byte_r   <= 8'h00;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            cd_q_r <= compute_done;
            case (state_r)
                S_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (start_s) begin
                        snap_r      <= pe_register_vals;
                        out_byte_r  <= HDR;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
`ifdef RESULT_DRAIN_CHECKSUM_EN
                        csum_r      <= 8'h00;
`endif
                        state_r     <= S_HDR;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_HDR: begin
                    if (xfer_s) begin
                        idx_r      <= next_idx_s;
                        byte_r     <= next_byte_s;
                        out_byte_r <= sel_byte_s;
                        state_r    <= S_DATA;
                    end else begin
                        state_r <= S_HDR;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
`ifdef RESULT_DRAIN_CHECKSUM_EN
                        csum_r <= csum_r + out_byte_r;
`endif
                        if (last_s) begin
`ifdef RESULT_DRAIN_CHECKSUM_EN
                            // Present the sum including the byte being accepted now
                            out_byte_r   <= csum_r + out_byte_r;
                            state_r      <= S_CSUM;
`else
                            out_valid_r  <= 1'b0;
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
                            state_r      <= S_FIN;
`endif
                        end else begin
                            idx_r      <= next_idx_s;
                            byte_r     <= next_byte_s;
                            out_byte_r <= sel_byte_s;
                        end
                    end else begin
                        state_r <= S_DATA;
                    end
                end
`ifdef RESULT_DRAIN_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer_s) begin
                        out_valid_r  <= 1'b0;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                        state_r      <= S_FIN;
                    end else begin
                        state_r <= S_CSUM;
                    end
                end
`endif
                S_FIN: begin
                    frame_done_r <= 1'b0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    out_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
